// File: rtl/optical_ook_receiver.sv
// OOK optical receiver: synchronizes the detector line, 3-sample majority votes each bit,
// frames start/data/stop into a parallel word and hands it off over valid/ready.
module optical_ook_receiver #(
  parameter int OVERSAMPLE  = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              opt_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state, state_next;
  logic [SYNC_STAGES-1:0]   sync;
  logic [1:0]               dly;
  logic [PH_W-1:0]          phase;
  logic [BC_W-1:0]          bit_cnt;
  logic [DATA_W-1:0]        sh, sh_next;
  logic                     s, v, s_rise;
  logic                     shift_en, phase_clr, done_ok, frame_bad;

  assign s      = sync[SYNC_STAGES-1];
  assign s_rise = s & ~dly[0];
  assign v      = (s & dly[0]) | (s & dly[1]) | (dly[0] & dly[1]);
  assign busy   = (state != IDLE);

  // New bit enters at the MSB so the first data bit ends up in the LSB.
  always_comb begin
    sh_next = sh >> 1;
    sh_next[DATA_W-1] = v;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    phase_clr  = 1'b0;
    done_ok    = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE:  if (s_rise) begin
               state_next = START;
               phase_clr  = 1'b1;
             end
      START: if (phase == PH_HALF) begin
               phase_clr  = 1'b1;
               state_next = v ? DATA : IDLE;
             end
      DATA:  if (phase == PH_LAST) begin
               shift_en  = 1'b1;
               phase_clr = 1'b1;
               if (bit_cnt == BC_LAST) state_next = STOP;
             end
      STOP:  if (phase == PH_LAST) begin
               phase_clr  = 1'b1;
               state_next = IDLE;
               frame_bad  = v;
               done_ok    = ~v;
             end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync      <= '0;
      dly       <= '0;
      phase     <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;
      sync  <= {sync[SYNC_STAGES-2:0], opt_in};
      dly   <= {dly[0], s};
      phase <= (phase_clr || state == IDLE) ? '0 : phase + 1'b1;
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) sh <= sh_next;
      frame_err <= frame_bad;
      overrun   <= done_ok & rx_valid & ~rx_ready;
      // A word landing on an unaccepted one is dropped; landing on an accept cycle replaces it.
      if (done_ok && !(rx_valid && !rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_optical_ook_receiver.sv
// Self-checking bench for optical_ook_receiver: frames driven bit-by-bit, expected words queued.
module tb_optical_ook_receiver;
  localparam int OS = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          opt_in = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b1;
  logic          frame_err, overrun, busy;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0, ov_cnt = 0, vld_cnt = 0;
  logic [DW-1:0] exp_q[$];

  optical_ook_receiver #(.OVERSAMPLE(OS), .DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .opt_in(opt_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid) vld_cnt++;
      if (rx_valid && rx_ready) begin
        logic [DW-1:0] e;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word got=%h expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            fails++;
            $display("FAIL word got=%h expected=%h", rx_data, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Bit i spans nominal edges i*OS+off[i] .. (i+1)*OS+off[i+1]; jitter moves each inner edge by -1..+1.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input bit jit);
    int off[DW+3];
    logic bits[DW+2];
    off[0] = 0;
    off[DW+2] = 0;
    for (int i = 1; i <= DW + 1; i++) off[i] = jit ? int'($urandom_range(0, 2)) - 1 : 0;
    bits[0] = 1'b1;
    for (int i = 0; i < DW; i++) bits[i+1] = d[i];
    bits[DW+1] = stop;
    for (int i = 0; i < DW + 2; i++) begin
      opt_in = bits[i];
      tick(OS + off[i+1] - off[i]);
    end
    opt_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {frame_err, overrun}, 0);
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_single();
    int v0 = vld_cnt, f0 = fe_cnt, o0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0);
    tick(12);
    check("single_drained", exp_q.size(), 0);
    check("single_valid_cycles", vld_cnt - v0, 1);
    check("single_no_err", (fe_cnt - f0) + (ov_cnt - o0), 0);
  endtask

  task automatic test_false_start();
    int v0 = vld_cnt;
    bit saw = 0;
    opt_in = 1'b1;
    tick(2);
    opt_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy) saw = 1;
      tick(1);
    end
    check("glitch_detected", saw, 1);
    check("glitch_busy_cleared", busy, 0);
    tick(10);
    check("glitch_no_valid", vld_cnt - v0, 0);
  endtask

  task automatic test_frame_err();
    int v0 = vld_cnt, f0 = fe_cnt;
    int busy_hits = 0;
    send_frame(8'h3C, 1'b1, 1'b0);
    opt_in = 1'b1;
    tick(6);
    for (int i = 0; i < 30; i++) begin
      if (busy) busy_hits++;
      tick(1);
    end
    check("ferr_pulse", fe_cnt - f0, 1);
    check("ferr_no_valid", vld_cnt - v0, 0);
    check("ferr_no_rearm", busy_hits, 0);
    opt_in = 1'b0;
    tick(10);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(12);
    check("ferr_recover", exp_q.size(), 0);
  endtask

  task automatic test_back_to_back();
    int o0 = ov_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    tick(12);
    check("ovr_pulse", ov_cnt - o0, 1);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h11);
    rx_ready = 1'b1;
    tick(2);
    check("ovr_accepted", exp_q.size(), 0);
    check("ovr_valid_drop", rx_valid, 0);
  endtask

  task automatic test_mid_reset();
    opt_in = 1'b1;
    tick(OS);
    tick(3 * OS);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    opt_in = 1'b0;
    tick(1);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_outputs", {rx_valid, frame_err, overrun}, 0);
    check("midrst_data", rx_data, 0);
    tick(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0);
    tick(12);
    check("midrst_next_frame", exp_q.size(), 0);
  endtask

  task automatic test_jitter();
    int f0 = fe_cnt;
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b0, 1'b1);
    tick(12);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b0, 1'b1);
    tick(12);
    check("jitter_drained", exp_q.size(), 0);
    check("jitter_no_err", fe_cnt - f0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_mid_reset();
    test_jitter();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
